player_packet_tx: RTL

- Downstream of the per-board game logic. Once per video frame it snapshots the local player's location, direction and state, plus the game state.
- It serializes the snapshot into a 7-byte checksummed packet on a valid/ready byte stream. The inter-board link serializer consumes this stream and forwards the packet to the other FPGAs, which feed their player_a/b/c coordinates.
- Runs on the system clock. vsync is treated as an asynchronous frame-tick input.

---
 rtl/player_packet_tx_if.sv | 11 +
 rtl/player_packet_tx.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/player_packet_tx_if.sv
// Byte-stream link between the packet transmitter and the inter-board serializer.
// A byte transfers on a rising clock edge where tx_valid && tx_ready; once raised,
// tx_valid and tx_data hold until that transfer, and tx_ready is ignored while tx_valid==0.
interface player_packet_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/player_packet_tx.sv
// Once per video frame, snapshots the local player and game state and streams it
// as a 7-byte XOR-checksummed packet to the inter-board link serializer.
module player_packet_tx #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         SYNC_STAGES = 2      // legal range 2..3
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       vsync,
  input  logic       tx_enable,
  input  logic [2:0] game_state,
  input  logic [1:0] local_player_ID,
  input  logic [3:0] player_state,
  input  logic [1:0] player_direction,
  input  logic [8:0] player_loc_x,
  input  logic [8:0] player_loc_y,
  player_packet_tx_if.master tx,
  output logic       busy,
  output logic [7:0] seq,
  output logic [7:0] drop_count,
  output logic       state_dbg
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                 state_q, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;
  logic                   pending_q;
  logic [2:0]             idx_q;
  logic [7:0]             pkt_q [6];   // B1..B6 of the packet in flight
  logic                   start, accept, last_byte;
  logic [7:0]             b1, b2, b3, b4, b5, b6;
  logic [7:0]             next_byte;

  assign state_dbg = (state_q == SEND);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], vsync};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Snapshot bytes built from the live inputs; only latched on the start edge.
  assign b1 = {1'b0, game_state, player_state};
  assign b2 = player_loc_x[7:0];
  assign b3 = player_loc_y[7:0];
  assign b4 = {local_player_ID, player_direction, 2'b00, player_loc_y[8], player_loc_x[8]};
  assign b5 = seq;
  assign b6 = SYNC_BYTE ^ b1 ^ b2 ^ b3 ^ b4 ^ b5;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    start      = 1'b0;
    accept     = 1'b0;
    last_byte  = 1'b0;
    case (state_q)
      IDLE: begin
        if ((rise || pending_q) && tx_enable) begin
          start      = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (tx.tx_valid && tx.tx_ready) begin
          accept = 1'b1;
          if (idx_q == 3'd6) begin
            last_byte  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte following the one currently on the bus.
  always_comb begin
    next_byte = 8'h00;
    case (idx_q)
      3'd0:    next_byte = pkt_q[0];
      3'd1:    next_byte = pkt_q[1];
      3'd2:    next_byte = pkt_q[2];
      3'd3:    next_byte = pkt_q[3];
      3'd4:    next_byte = pkt_q[4];
      3'd5:    next_byte = pkt_q[5];
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      tx.tx_data  <= 8'h00;
      tx.tx_valid <= 1'b0;
      busy        <= 1'b0;
      seq         <= 8'h00;
      drop_count  <= 8'h00;
      pending_q   <= 1'b0;
      idx_q       <= 3'd0;
      pkt_q       <= '{default: 8'h00};
    end else begin
      if (start) begin
        pkt_q       <= '{b1, b2, b3, b4, b5, b6};
        tx.tx_data  <= SYNC_BYTE;
        tx.tx_valid <= 1'b1;
        busy        <= 1'b1;
        idx_q       <= 3'd0;
      end else if (accept) begin
        if (last_byte) begin
          tx.tx_data  <= 8'h00;
          tx.tx_valid <= 1'b0;
          busy        <= 1'b0;
          seq         <= seq + 8'd1;
        end else begin
          tx.tx_data <= next_byte;
          idx_q      <= idx_q + 3'd1;
        end
      end

      // One deferred packet at most; further requests in flight are only counted.
      if (state_q == IDLE) begin
        if (start || !tx_enable) pending_q <= 1'b0;
      end else if (rise) begin
        if (!pending_q)                pending_q  <= 1'b1;
        else if (drop_count != 8'hFF)  drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule
